// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared types for the two-requester ROM arbiter
//
// Purpose: requester id encoding and the pipeline stage tag used by
//          rom_arbiter and its round-robin picker.
// Ports:   none (package).
package rom_arbiter_pkg;

    // Requester id: 0 = requester 0, 1 = requester 1.
    typedef logic req_id_t;

    // Tag carried alongside each in-flight ROM access.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// rtl/rom_arbiter_rr_pick2.sv - two-way round-robin picker (combinational)
//
// Purpose: choose one of two eligible requesters, using pointer to break ties.
// Ports:
//   eligible    in  [1:0]  per-requester eligibility (req and not busy)
//   pointer     in  1      preferred requester when both are eligible
//   grant_valid out 1      at least one requester eligible
//   grant_id    out 1      winning requester
module rom_arbiter_rr_pick2
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  req_id_t    pointer,
    output logic       grant_valid,
    output req_id_t    grant_id
);

    always_comb begin
        grant_valid = |eligible;
        grant_id    = 1'b0;
        case (eligible)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = pointer;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin sharing of one registered-output ROM by two requesters
//
// Purpose: grant one request per cycle, drive the ROM address, track the owner
//          of each in-flight access through the ROM latency, and return the
//          data with a one-cycle acknowledge.
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   req0/addr0          requester 0 request (held until ack0) and address
//   ack0/data0          requester 0 acknowledge pulse and registered data
//   req1/addr1          requester 1 request and address
//   ack1/data1          requester 1 acknowledge pulse and registered data
//   rom_address         registered ROM address
//   rom_q               ROM registered output, valid one cycle after rom_address
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic [A_WIDTH-1:0] addr0,
    output logic               ack0,
    output logic [D_WIDTH-1:0] data0,
    input  logic               req1,
    input  logic [A_WIDTH-1:0] addr1,
    output logic               ack1,
    output logic [D_WIDTH-1:0] data1,
    output logic [A_WIDTH-1:0] rom_address,
    input  logic [D_WIDTH-1:0] rom_q
);

    logic [A_WIDTH-1:0] rom_address_q, rom_address_d;
    tag_t               tag1_q, tag1_d;
    tag_t               tag2_q, tag2_d;
    logic [1:0]         busy_q, busy_d;
    req_id_t            pointer_q, pointer_d;
    logic [1:0]         ack_q, ack_d;
    logic [D_WIDTH-1:0] data0_q, data0_d;
    logic [D_WIDTH-1:0] data1_q, data1_d;

    logic [1:0] eligible;
    logic       grant_valid;
    req_id_t    grant_id;

    // A requester with an access in flight is not eligible, so it cannot be
    // granted twice before its ack.
    assign eligible = {req1 & ~busy_q[1], req0 & ~busy_q[0]};

    rom_arbiter_rr_pick2 u_pick (
        .eligible    (eligible),
        .pointer     (pointer_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        rom_address_d = rom_address_q;
        tag1_d        = '0;
        tag2_d        = tag1_q;
        busy_d        = busy_q;
        pointer_d     = pointer_q;
        ack_d         = 2'b00;
        data0_d       = data0_q;
        data1_d       = data1_q;

        // Return stage: the ROM output now belongs to the access tagged two
        // edges ago.
        if (tag2_q.valid) begin
            ack_d[tag2_q.id]  = 1'b1;
            busy_d[tag2_q.id] = 1'b0;
            if (tag2_q.id) begin
                data1_d = rom_q;
            end else begin
                data0_d = rom_q;
            end
        end

        // Grant stage. The winner is never busy, so it never collides with
        // the busy bit cleared by the return stage above.
        if (grant_valid) begin
            rom_address_d    = grant_id ? addr1 : addr0;
            tag1_d           = '{valid: 1'b1, id: grant_id};
            busy_d[grant_id] = 1'b1;
            pointer_d        = ~grant_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_address_q <= '0;
            tag1_q        <= '0;
            tag2_q        <= '0;
            busy_q        <= 2'b00;
            pointer_q     <= 1'b0;
            ack_q         <= 2'b00;
            data0_q       <= '0;
            data1_q       <= '0;
        end else begin
            rom_address_q <= rom_address_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            busy_q        <= busy_d;
            pointer_q     <= pointer_d;
            ack_q         <= ack_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
        end
    end

    assign rom_address = rom_address_q;
    assign ack0        = ack_q[0];
    assign ack1        = ack_q[1];
    assign data0       = data0_q;
    assign data1       = data1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard bench for rom_arbiter
module tb_rom_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [11:0] addr0, addr1;
    logic        ack0, ack1;
    logic [7:0]  data0, data1;
    logic [11:0] rom_address;
    logic [7:0]  rom_q;

    logic [7:0] rom_mem [0:4095];

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit sustain_mode = 0;
    bit b2b_mode     = 0;
    int last_id      = -1;
    int last_ack0    = -1;
    int last_ack1    = -1;
    int last_addr_chg = -1;
    logic [11:0] prev_addr = '0;

    rom_arbiter #(.A_WIDTH(12), .D_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req0        (req0),
        .addr0       (addr0),
        .ack0        (ack0),
        .data0       (data0),
        .req1        (req1),
        .addr1       (addr1),
        .ack1        (ack1),
        .data1       (data1),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 clock = ~clock;

    // Registered-output ROM model.
    always @(posedge clock) rom_q <= rom_mem[rom_address];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input int act);
        n_checks++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: got %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT acknowledges.
    always @(negedge clock) begin
        if (!reset) begin
            if (ack0) begin
                if (q0.size() == 0) begin
                    check_true("unexpected_ack0", 1'b0, cyc);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("data0", data0, e.data);
                    if (e.cyc >= 0) check("ack0_cycle", cyc, e.cyc);
                end
                if (sustain_mode) begin
                    check_true("alternate_ack0", last_id != 0, last_id);
                    if (last_ack0 >= 0)
                        check_true("gap0", (cyc - last_ack0) inside {2, 3}, cyc - last_ack0);
                    last_id   = 0;
                    last_ack0 = cyc;
                end
            end
            if (ack1) begin
                if (q1.size() == 0) begin
                    check_true("unexpected_ack1", 1'b0, cyc);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("data1", data1, e.data);
                    if (e.cyc >= 0) check("ack1_cycle", cyc, e.cyc);
                end
                if (sustain_mode) begin
                    check_true("alternate_ack1", last_id != 1, last_id);
                    if (last_ack1 >= 0)
                        check_true("gap1", (cyc - last_ack1) inside {2, 3}, cyc - last_ack1);
                    last_id   = 1;
                    last_ack1 = cyc;
                end
            end
            if (b2b_mode && rom_address != prev_addr) begin
                check("b2b_addr_value", rom_address, addr1);
                if (last_addr_chg >= 0)
                    check_true("b2b_addr_spacing", (cyc - last_addr_chg) >= 3, cyc - last_addr_chg);
                last_addr_chg = cyc;
            end
        end
        prev_addr = rom_address;
    end

    // Issue one read; the expected response is pushed before waiting.
    // lat < 0 means the ack cycle is not checked for this request.
    task automatic read_req(input int id, input logic [11:0] a, input logic [7:0] exp, input int lat);
        exp_t e;
        int   n;
        bit   got;
        e.data = exp;
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        if (id == 0) begin
            req0 = 1'b1; addr0 = a; q0.push_back(e);
        end else begin
            req1 = 1'b1; addr1 = a; q1.push_back(e);
        end
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clock); #1;
            n++;
            got = (id == 0) ? ack0 : ack1;
        end
        if (!got) check_true("ack_timeout", 1'b0, id);
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h5A ^ i[7:0];
        rom_mem[12'h123] = 8'hA5;
        rom_mem[12'h010] = 8'h11;
        rom_mem[12'h020] = 8'h22;

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("idle_ack0", ack0, 0);
            check("idle_ack1", ack1, 0);
            check("idle_data0", data0, 0);
            check("idle_data1", data1, 0);
            check("idle_rom_address", rom_address, 0);
        end

        // Single read with address check one cycle after the request.
        fork
            read_req(0, 12'h123, 8'hA5, 3);
            begin
                @(posedge clock); #1;
                check("single_rom_address", rom_address, 12'h123);
            end
        join
        repeat (3) begin @(posedge clock); #1; end

        // Contention straight after reset: requester 0 first.
        do_reset();
        fork
            read_req(0, 12'h010, 8'h11, 3);
            read_req(1, 12'h020, 8'h22, 4);
        join
        repeat (4) begin @(posedge clock); #1; end

        // Sustained contention.
        sustain_mode = 1; last_id = -1; last_ack0 = -1; last_ack1 = -1;
        fork
            for (int k = 0; k < 7; k++) read_req(0, 12'h040 + 12'(k), 8'h1A ^ 8'(k), -1);
            for (int k = 0; k < 7; k++) read_req(1, 12'h080 + 12'(k), 8'hDA ^ 8'(k), -1);
        join
        @(negedge clock);
        sustain_mode = 0;
        repeat (4) begin @(posedge clock); #1; end

        // Back-to-back single requester.
        b2b_mode = 1; last_addr_chg = -1;
        read_req(1, 12'h000, 8'h5A, 3);
        read_req(1, 12'h001, 8'h5B, 3);
        read_req(1, 12'h002, 8'h58, 3);
        read_req(1, 12'h003, 8'h59, 3);
        @(negedge clock);
        b2b_mode = 0;
        repeat (3) begin @(posedge clock); #1; end

        // Abandoned request: dropped one cycle after the grant.
        begin
            exp_t e;
            e.data = 8'h0F; e.cyc = cyc + 3;
            q0.push_back(e);
            req0 = 1'b1; addr0 = 12'h155;
            @(posedge clock); #1;
            @(posedge clock); #1;
            req0 = 1'b0;
            repeat (12) begin @(posedge clock); #1; end
            check("abandon_no_regrant_addr", rom_address, 12'h155);
            check("abandon_acked", q0.size(), 0);
        end

        // Reset during an in-flight access: no ack, data cleared.
        req0 = 1'b1; addr0 = 12'h2AA;
        @(posedge clock); #1;
        reset = 1'b1; req0 = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("rst_ack0", ack0, 0);
            check("rst_ack1", ack1, 0);
        end
        check("rst_data0", data0, 0);
        check("rst_data1", data1, 0);
        check("rst_rom_address", rom_address, 0);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
